// File: rtl/ahbl_dma_master.sv
// rtl/ahbl_dma_master.sv - single-channel AHB-Lite memory-to-memory DMA master
//
// Copies `count` elements of 1, 2 or 4 bytes from src_addr to dst_addr.
// Each element is one non-pipelined read and then one non-pipelined write.
// Build option: define DMA_ALIGN_CHK_EN to reject a reserved size or a
// misaligned request at start. The request ends with err=1 and no bus activity.
//
// Ports:
//   HCLK, HRESET                     clock, asynchronous active-high reset
//   start, src_addr, dst_addr,       request; sampled only while idle
//   count, size
//   busy, done, err                  status (done is a one-cycle pulse, err sticky)
//   HADDR, HTRANS, HSIZE, HWRITE,    AHB-Lite master outputs, all registered
//   HWDATA
//   HREADY, HRDATA, HRESP            AHB-Lite master inputs
module ahbl_dma_master #(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       size,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  input  logic             HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_DONE} state_t;

  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       esize;
  logic [31:0]      elem;

  logic [1:0]  req_size;
  logic        req_bad;
  logic [31:0] inc;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_rep;

  // The reserved size code is carried out as a word copy, on the bus too.
  assign req_size = (size == 2'd3) ? 2'd2 : size;
  assign inc      = 32'd1 << esize;

`ifdef DMA_ALIGN_CHK_EN
  assign req_bad = (size == 2'd3) ||
                   ((size == 2'd1) && (src_addr[0] || dst_addr[0])) ||
                   ((size == 2'd2) && ((src_addr[1:0] != 2'd0) || (dst_addr[1:0] != 2'd0)));
`else
  assign req_bad = 1'b0;
`endif

  // The element is stored already replicated across the bus, so the write
  // data phase just forwards it and any lane the slave picks is correct.
  always_comb begin
    rd_byte = HRDATA[{src[1:0], 3'b000} +: 8];
    rd_half = src[1] ? HRDATA[31:16] : HRDATA[15:0];
    case (esize)
      2'd0:    rd_rep = {4{rd_byte}};
      2'd1:    rd_rep = {2{rd_half}};
      default: rd_rep = HRDATA;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      esize     <= '0;
      elem      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HSIZE     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= count;
            esize     <= req_size;
            HSIZE     <= {1'b0, req_size};
            err       <= req_bad;
            if ((count == '0) || req_bad) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_RD_A;
              busy   <= 1'b1;
              HADDR  <= src_addr;
              HTRANS <= TR_NONSEQ;
              HWRITE <= 1'b0;
            end
          end
        end
        S_RD_A: begin
          if (HREADY) begin
            state  <= S_RD_D;
            HTRANS <= TR_IDLE;
          end
        end
        S_RD_D: begin
          // An error response aborts on its first cycle; nothing more is issued.
          if (HRESP) begin
            state <= S_DONE;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (HREADY) begin
            elem   <= rd_rep;
            state  <= S_WR_A;
            HADDR  <= dst;
            HTRANS <= TR_NONSEQ;
            HWRITE <= 1'b1;
          end
        end
        S_WR_A: begin
          if (HREADY) begin
            state  <= S_WR_D;
            HTRANS <= TR_IDLE;
            HWDATA <= elem;
          end
        end
        S_WR_D: begin
          if (HRESP) begin
            state  <= S_DONE;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            HWRITE <= 1'b0;
          end else if (HREADY) begin
            src       <= src + inc;
            dst       <= dst + inc;
            remaining <= remaining - 1'b1;
            HWRITE    <= 1'b0;
            if (remaining == CNT_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state  <= S_RD_A;
              HADDR  <= src + inc;
              HTRANS <= TR_NONSEQ;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_dma_master.sv
// tb/tb_ahbl_dma_master.sv - self-checking bench for ahbl_dma_master
module tb_ahbl_dma_master;
  localparam int CNT_W = 16;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [CNT_W-1:0] count = '0;
  logic [1:0]       size = '0;
  logic             busy, done, err;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE;
  logic             HWRITE;
  logic [31:0]      HWDATA;
  logic             HREADY = 1'b1;
  logic [31:0]      HRDATA = '0;
  logic             HRESP = 1'b0;

  ahbl_dma_master #(.CNT_W(CNT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .count(count), .size(size), .busy(busy), .done(done),
    .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memories: slave image and expected image -------------
  logic [7:0] mem     [0:4095];
  logic [7:0] exp_mem [0:4095];

  function automatic logic [31:0] rep(input logic [31:0] el, input logic [1:0] eff);
    case (eff)
      2'd0:    return {4{el[7:0]}};
      2'd1:    return {2{el[15:0]}};
      default: return el;
    endcase
  endfunction

  // An element lives at its address rounded down to its own size.
  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] eff);
    logic [11:0] a;
    a = addr[11:0];
    case (eff)
      2'd0:    return {24'd0, exp_mem[a]};
      2'd1:    return {16'd0, exp_mem[{a[11:1], 1'b1}], exp_mem[{a[11:1], 1'b0}]};
      default: return {exp_mem[{a[11:2], 2'd3}], exp_mem[{a[11:2], 2'd2}],
                       exp_mem[{a[11:2], 2'd1}], exp_mem[{a[11:2], 2'd0}]};
    endcase
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] el, input logic [1:0] eff);
    logic [11:0] a;
    a = addr[11:0];
    case (eff)
      2'd0: exp_mem[a] = el[7:0];
      2'd1: begin
        exp_mem[{a[11:1], 1'b0}] = el[7:0];
        exp_mem[{a[11:1], 1'b1}] = el[15:8];
      end
      default: for (int j = 0; j < 4; j++) exp_mem[{a[11:2], 2'(j)}] = el[8*j +: 8];
    endcase
  endtask

  task automatic set_word(input logic [11:0] a, input logic [31:0] v);
    for (int j = 0; j < 4; j++) begin
      mem[a + 12'(j)]     = v[8*j +: 8];
      exp_mem[a + 12'(j)] = v[8*j +: 8];
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  task automatic check_mem();
    int nbad;
    int first;
    nbad = 0;
    first = -1;
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== exp_mem[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    n_tests++;
    if (nbad != 0) begin
      n_fail++;
      $display("FAIL mem: %0d bytes differ, first at %h got %h expected %h",
               nbad, first, mem[first], exp_mem[first]);
    end
  endtask

  // ---------------- AHB-Lite slave model ---------------------------------
  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr  = '0;
  logic [1:0]  dp_size  = '0;
  int          dp_idx   = -1;
  int          phase_cnt = 0;
  logic [11:0] sa;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
    end else begin
      if (dp_valid && HREADY) begin
        if (dp_write && !HRESP) begin
          sa = dp_addr[11:0];
          case (dp_size)
            2'd0: mem[sa] <= HWDATA[8*sa[1:0] +: 8];
            2'd1: begin
              mem[{sa[11:1], 1'b0}] <= HWDATA[16*sa[1] +: 8];
              mem[{sa[11:1], 1'b1}] <= HWDATA[16*sa[1] + 8 +: 8];
            end
            default: for (int j = 0; j < 4; j++) mem[{sa[11:2], 2'(j)}] <= HWDATA[8*j +: 8];
          endcase
        end
        dp_valid <= 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        dp_valid  <= 1'b1;
        dp_write  <= HWRITE;
        dp_addr   <= HADDR;
        dp_size   <= HSIZE[1:0];
        dp_idx    <= phase_cnt;
        phase_cnt <= phase_cnt + 1;
      end
    end
  end

  int wait_mode = 0;     // 0 none, 1 random 0..2 per data phase, 2 two per read data phase
  int wait_left = 0;
  int cur_idx   = -1;
  int W         = 0;     // total wait cycles inserted, never reset
  int err_abs   = -1;    // absolute data-phase index that gets HRESP
  logic [11:0] ra_base;

  always @(negedge HCLK) begin
    if (dp_valid && !HRESET) begin
      if (dp_idx != cur_idx) begin
        cur_idx = dp_idx;
        case (wait_mode)
          1:       wait_left = int'($urandom_range(2, 0));
          2:       wait_left = dp_write ? 0 : 2;
          default: wait_left = 0;
        endcase
      end
      if (wait_left > 0) begin
        HREADY = 1'b0;
        HRESP  = 1'b0;
        wait_left--;
        W++;
      end else begin
        HREADY = 1'b1;
        HRESP  = (dp_idx == err_abs);
      end
      ra_base = {dp_addr[11:2], 2'b00};
      HRDATA = {mem[ra_base + 12'd3], mem[ra_base + 12'd2], mem[ra_base + 12'd1], mem[ra_base]};
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = $urandom;
    end
  end

  // ---------------- job model and per-cycle compare ----------------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] exp_wd = '0;
  bit          in_job = 0;
  bit          exp_err_v = 0;
  int          t0 = 0;
  int          P = 0;
  int          W_base = 0;
  int          done_cyc = -1;
  int          rel_c;
  bit          ed_c;

  // done lands one cycle after all address/data phase pairs plus every wait.
  always @(negedge HCLK) begin
    #2;
    if (!HRESET) begin
      if (in_job) begin
        rel_c = cyc - t0 + 1;
        ed_c  = (rel_c == 2 * P + 1 + (W - W_base));
        chk("done", done, ed_c);
        chk("busy", busy, !ed_c);
        chk("err", err, ed_c ? exp_err_v : 1'b0);
        if (done) begin
          done_cyc = rel_c;
          in_job = 0;
        end
      end else begin
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
      end
      if (HTRANS == 2'b10) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_nonseq: got NONSEQ at %h, expected no transfer", HADDR);
        end else begin
          chk("haddr", HADDR, q[0].addr);
          chk("hwrite", HWRITE, q[0].wr);
          chk("hsize", HSIZE, q[0].sz);
          if (HREADY) begin
            if (q[0].wr) exp_wd = q[0].wdata;
            void'(q.pop_front());
          end
        end
      end else begin
        chk("htrans", HTRANS, 2'b00);
      end
      if (dp_valid && dp_write) chk("hwdata", HWDATA, exp_wd);
    end
  end

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic [1:0] sz, input int err_k, input int wmode,
                         input int wr_limit, input int reset_at);
    logic [1:0]  eff;
    int          es;
    bit          bad;
    logic [31:0] el;
    xfer_t       x;
    @(negedge HCLK);
    eff = (sz == 2'd3) ? 2'd2 : sz;
    es  = 1 << eff;
    bad = 0;
`ifdef DMA_ALIGN_CHK_EN
    bad = (sz == 2'd3) || (sz == 2'd1 && (s[0] || d[0])) ||
          (sz == 2'd2 && (s[1:0] != 2'd0 || d[1:0] != 2'd0));
`endif
    q.delete();
    P = 0;
    exp_err_v = bad;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        x.addr = s + 32'(i * es); x.wr = 1'b0; x.sz = {1'b0, eff}; x.wdata = '0;
        q.push_back(x);
        P++;
        if (err_k == 2 * i) begin exp_err_v = 1; break; end
        el = model_read(x.addr, eff);
        x.addr = d + 32'(i * es); x.wr = 1'b1; x.wdata = rep(el, eff);
        q.push_back(x);
        P++;
        if (err_k == 2 * i + 1) begin exp_err_v = 1; break; end
        if (i < wr_limit) model_write(x.addr, el, eff);
      end
    end
    err_abs   = (err_k >= 0) ? phase_cnt + err_k : -1;
    wait_mode = wmode;
    W_base    = W;
    src_addr  = s;
    dst_addr  = d;
    count     = CNT_W'(n);
    size      = sz;
    start     = 1'b1;
    t0        = cyc + 1;
    done_cyc  = -1;
    @(posedge HCLK);
    #1;
    start  = 1'b0;
    in_job = 1;
    if (reset_at > 0) begin
      for (int k = 0; k < 200; k++) begin
        if (cyc - t0 + 1 == reset_at) break;
        @(negedge HCLK);
      end
      #3;
      HRESET = 1'b1;
      #1;
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", HWRITE, 0);
      in_job = 0;
      q.delete();
      err_abs = -1;
      @(negedge HCLK);
      #3;
      HRESET = 1'b0;
    end else begin
      for (int k = 0; k < 500 && in_job; k++) @(negedge HCLK);
      #3;
      if (in_job) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: done never seen, expected within 500 cycles");
        in_job = 0;
      end
      chk("xfers_left", q.size(), 0);
    end
    check_mem();
    repeat (2) @(negedge HCLK);
    #3;
    chk("err_sticky", err, exp_err_v);
    wait_mode = 0;
    err_abs = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]  nb_lo, nb_hi;
  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    set_word(12'h000, 32'h11);
    set_word(12'h004, 32'h22);
    set_word(12'h008, 32'h33);
    set_word(12'h00C, 32'h44);

    // Model pins
    chk("model_rep_b", rep(32'h000000AB, 2'd0), 32'hABABABAB);
    chk("model_rep_h", rep(32'h00001234, 2'd1), 32'h12341234);
    chk("model_read_w", model_read(32'h00000008, 2'd2), 32'h00000033);

    // Reset state
    repeat (3) @(negedge HCLK);
    #3;
    chk("rv_busy", busy, 0);
    chk("rv_done", done, 0);
    chk("rv_err", err, 0);
    chk("rv_haddr", HADDR, 32'h0);
    chk("rv_htrans", HTRANS, 2'b00);
    chk("rv_hsize", HSIZE, 3'd0);
    chk("rv_hwrite", HWRITE, 0);
    chk("rv_hwdata", HWDATA, 32'h0);
    HRESET = 1'b0;

    // Word copy
    run_job(32'h000, 32'h100, 4, 2'd2, -1, 0, 99, 0);
    chk("word_done_cyc", done_cyc, 17);
    chk("word_err", err, 0);
    chk("word_d0", mem_word(12'h100), 32'h11);
    chk("word_d1", mem_word(12'h104), 32'h22);
    chk("word_d2", mem_word(12'h108), 32'h33);
    chk("word_d3", mem_word(12'h10C), 32'h44);

    // Byte copy
    mem[12'h101] = 8'hAA; exp_mem[12'h101] = 8'hAA;
    mem[12'h102] = 8'hBB; exp_mem[12'h102] = 8'hBB;
    mem[12'h103] = 8'hCC; exp_mem[12'h103] = 8'hCC;
    nb_lo = mem[12'h201];
    nb_hi = mem[12'h205];
    run_job(32'h101, 32'h202, 3, 2'd0, -1, 0, 99, 0);
    chk("byte_done_cyc", done_cyc, 13);
    chk("byte_202", mem[12'h202], 8'hAA);
    chk("byte_203", mem[12'h203], 8'hBB);
    chk("byte_204", mem[12'h204], 8'hCC);
    chk("byte_201_kept", mem[12'h201], nb_lo);
    chk("byte_205_kept", mem[12'h205], nb_hi);

    // Zero count
    run_job(32'h000, 32'h300, 0, 2'd2, -1, 0, 99, 0);
    chk("zero_done_cyc", done_cyc, 1);

    // Two wait states in every read data phase
    run_job(32'h000, 32'h400, 2, 2'd2, -1, 2, 99, 0);
    chk("wait_done_cyc", done_cyc, 13);
    chk("wait_d1", mem_word(12'h404), 32'h22);

    // Error response on the second read
    saved = mem_word(12'h504);
    run_job(32'h000, 32'h500, 4, 2'd2, 2, 0, 99, 0);
    chk("rerr_done_cyc", done_cyc, 7);
    chk("rerr_err", err, 1);
    chk("rerr_d0", mem_word(12'h500), 32'h11);
    chk("rerr_d1_kept", mem_word(12'h504), saved);

    // Misaligned word request
    run_job(32'h002, 32'h600, 2, 2'd2, -1, 0, 99, 0);
`ifdef DMA_ALIGN_CHK_EN
    chk("align_done_cyc", done_cyc, 1);
    chk("align_err", err, 1);
`else
    chk("align_done_cyc", done_cyc, 9);
    chk("align_err", err, 0);
`endif

    // Reset during WR_A of element 2, then a clean copy
    run_job(32'h000, 32'h700, 4, 2'd2, -1, 0, 1, 7);
    chk("rst_d0", mem_word(12'h700), 32'h11);
    run_job(32'h000, 32'h740, 4, 2'd2, -1, 0, 99, 0);
    chk("post_rst_done_cyc", done_cyc, 17);
    chk("post_rst_d3", mem_word(12'h74C), 32'h44);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      logic [1:0]  rs;
      int          res, rn, rk;
      logic [31:0] rsrc, rdst;
      rs   = 2'($urandom_range(3, 0));
      res  = (rs == 2'd0) ? 1 : (rs == 2'd1) ? 2 : 4;
      rn   = int'($urandom_range(8, 0));
      rsrc = 32'($urandom_range(992, 0)) & ~32'(res - 1);
      rdst = 32'h800 + (32'($urandom_range(992, 0)) & ~32'(res - 1));
      rk   = -1;
      if (rn > 0 && $urandom_range(3, 0) == 0) rk = int'($urandom_range(2 * rn - 1, 0));
      run_job(rsrc, rdst, rn, rs, rk, int'($urandom_range(1, 0)), 99, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
